ffsr_pulse_binary_tx: RTL and testbench
=======================================

# ffsr_pulse_binary_tx

Transmit-side driver for the pulse-binary up/down counter: accepts a binary target value over a valid/ready handshake and emits the exact sequence of `inc` or `dec` pulses that moves the downstream counter from its current value to the target. It keeps a shadow copy of the downstream counter, so it never requests a step past 0 or the maximum. It sits between the weight/update logic and each pulse-binary storage cell.

## Interface
Parameters:
- `WIDTH`, 3, bit width of target, shadow and downstream counter.

Ports:
- `clk`  input  1  single clock; all logic is on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `clr`  input  1  synchronous clear: aborts any transfer and zeroes the shadow.
- `tgt_valid`  input  1  target offered.
- `tgt`  input  WIDTH  target value, unsigned.
- `tgt_ready`  output  1  block can accept a target; high only in IDLE.
- `inc`  output  1  registered increment pulse to the downstream counter.
- `dec`  output  1  registered decrement pulse to the downstream counter.
- `clr_o`  output  1  registered one-cycle pulse that drives the downstream counter reset.
- `shadow`  output  WIDTH  mirror of the downstream counter value.
- `busy`  output  1  transfer in progress.
- `done`  output  1  one-cycle pulse when a transfer completes.

## Operation
- Reset values: `inc`=0, `dec`=0, `clr_o`=0, `shadow`=0, `busy`=0, `done`=0, `tgt_ready`=1, state IDLE.
- State IDLE:
  - A handshake completes when `tgt_valid` and `tgt_ready` are both high. It latches `tgt` into `tgt_q`.
  - If `tgt_q == shadow`: no pulses are issued, `done`=1 in the next cycle, and the state stays IDLE.
  - Otherwise the state moves to STEP and `busy`=1.
- State STEP:
  - Each cycle, drive `inc`=1 if `tgt_q > shadow_next_pending`, or `dec`=1 if lower. Never drive both.
  - `shadow` updates on the same edge on which the downstream counter samples the pulse: `shadow <= shadow + inc - dec`.
  - When the last required pulse has been issued, go to IDLE. `done`=1 for the cycle after the last pulse cycle; `busy`=0 and `tgt_ready`=1 in that same cycle.
- State GAP: exists only with `PULSE_GAP_EN` (see Configuration).
- Arithmetic:
  - Comparisons are unsigned on WIDTH bits.
  - Pulse count N = |tgt − shadow|, which is at most 2^WIDTH − 1.
  - `shadow` never wraps, because the target is always in range.
- `clr`:
  - Has priority over everything in every state.
  - Next cycle: `inc`/`dec`=0, `shadow`=0, state IDLE, `clr_o`=1 for one cycle.
  - No `done` is issued for an aborted transfer.
  - If `clr` and a handshake coincide, the target is dropped.
- `tgt_valid` while busy: ignored because `tgt_ready`=0. The upstream side holds it.
- Asynchronous reset mid-transfer: all outputs return to their reset values immediately. The downstream counter is expected to be reset by the same system reset.

## Timing
- Handshake at edge k, with N ≥ 1 and no gap:
  - `inc`/`dec` high during cycles k+1 … k+N.
  - `done` high in cycle k+N+1.
  - Next target accepted no earlier than edge k+N+1.
- Handshake at edge k with N = 0: `done` high in cycle k+1.
- `shadow` equals the downstream counter value at every cycle boundary.
- Throughput: one step per cycle.

## Configuration
- Macro: `FFSR_PULSE_GAP_EN`.
- Defined:
  - After each pulse cycle, the FSM enters GAP for one cycle with `inc`=`dec`=0, then returns to STEP. No GAP follows the final pulse.
  - Pulses occupy cycles k+1, k+3, …, k+2N−1.
  - `done` is high in cycle k+2N.
  - Use this setting for edge-sensitive downstream pulse detectors.
- Undefined: the GAP state is absent, and `inc`/`dec` may stay high across consecutive cycles.

## Structure
- Shared package `ffsr_pulse_pkg`:
  - Default `FFSR_WIDTH` = 3.
  - State enum: IDLE, STEP, GAP.
  - Direction enum: UP, DOWN, NONE.
  - This package is shared with the receiver-side counter.
- One sub-module, `ffsr_shadow_ctr`:
  - WIDTH-bit register.
  - Inputs: `inc`, `dec`, `clr`.
  - Identical update rule to the downstream counter; instantiated for `shadow`.
- The FSM, target latch and pulse registers live in the top module.

## Test plan
- Reset then target 5 → `inc` high for 5 consecutive cycles, `shadow` goes 1, 2, 3, 4, 5, `done` high in the 6th cycle after the handshake, `dec` never high.
- From shadow 5, target 2 → 3 `dec` pulses, `shadow` ends at 2, `done` follows one cycle after the last pulse.
- From shadow 2, target 2 → no pulses, `done` in the cycle after the handshake, `tgt_ready` stays high.
- Target 7 from shadow 0, assert `clr` in the 3rd pulse cycle → `inc` low the next cycle, `shadow`=0, `clr_o` single pulse, no `done`, `tgt_ready`=1.
- Drop `rst_n` during a transfer → all outputs go to reset values asynchronously. After release, target 0 gives N = 0 behaviour.
- With `FFSR_PULSE_GAP_EN` defined, target 3 from 0 → `inc` in cycles k+1, k+3, k+5 only, `done` at k+6. A co-simulated downstream counter matches `shadow` throughout.

Source files
------------

// File: rtl/ffsr_pulse_pkg.sv
// Shared types for the pulse-binary counter pair (tx driver and rx counter).
// Optional inter-pulse gap is enabled by FFSR_PULSE_GAP_EN.
package ffsr_pulse_pkg;

  localparam int FFSR_WIDTH = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    GAP  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    UP   = 2'd0,
    DOWN = 2'd1,
    NONE = 2'd2
  } dir_e;

  function automatic dir_e dir_of(
    input logic [31:0] want,
    input logic [31:0] have
  );
    dir_e d;
    d = NONE;
    unique case (1'b1)
      (want > have): d = UP;
      (want < have): d = DOWN;
      default:       d = NONE;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/ffsr_pulse_binary_tx_if.sv
// Target handshake between update logic (master) and the pulse driver (slave).
// Signal names follow the driver's tgt_* port naming.
interface ffsr_pulse_binary_tx_if
  import ffsr_pulse_pkg::*;
#(
  parameter int WIDTH = FFSR_WIDTH
);

  logic             tgt_valid;
  logic [WIDTH-1:0] tgt;
  logic             tgt_ready;

  modport master (
    output tgt_valid,
    output tgt,
    input  tgt_ready
  );

  modport slave (
    input  tgt_valid,
    input  tgt,
    output tgt_ready
  );

endinterface

// File: rtl/ffsr_shadow_ctr.sv
// Mirror of the downstream pulse-binary counter; same update rule.
// Synchronous clr wins over any step sampled on the same edge.
module ffsr_shadow_ctr
  import ffsr_pulse_pkg::*;
#(
  parameter int WIDTH = FFSR_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else
      cnt_d = cnt_q + WIDTH'(inc) - WIDTH'(dec);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/ffsr_pulse_binary_tx.sv
// Pulse-binary transmit driver: walks the downstream counter to a target.
// Define FFSR_PULSE_GAP_EN to insert one idle cycle between pulses.
module ffsr_pulse_binary_tx
  import ffsr_pulse_pkg::*;
#(
  parameter int WIDTH = FFSR_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  ffsr_pulse_binary_tx_if.slave  tgt_if,
  output logic                   inc,
  output logic                   dec,
  output logic                   clr_o,
  output logic [WIDTH-1:0]       shadow,
  output logic                   busy,
  output logic                   done
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic             inc_q, inc_d;
  logic             dec_q, dec_d;
  logic             done_q, done_d;
  logic             clr_o_q, clr_o_d;
  logic [WIDTH-1:0] pend;
  logic             hs;
  dir_e             dir_new;
  dir_e             dir_cur;

  ffsr_shadow_ctr #(
    .WIDTH (WIDTH)
  ) u_shadow (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (inc_q),
    .dec   (dec_q),
    .cnt   (shadow)
  );

  // Value the downstream counter will hold once the pulse in flight lands
  assign pend    = shadow + WIDTH'(inc_q) - WIDTH'(dec_q);
  assign hs      = tgt_if.tgt_valid & tgt_if.tgt_ready;
  assign dir_new = dir_of(32'(tgt_if.tgt), 32'(pend));
  assign dir_cur = dir_of(32'(tgt_q), 32'(pend));

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    inc_d   = 1'b0;
    dec_d   = 1'b0;
    done_d  = 1'b0;
    clr_o_d = 1'b0;
    if (clr) begin
      state_d = IDLE;
      clr_o_d = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (hs) begin
            tgt_d = tgt_if.tgt;
            if (dir_new == NONE) begin
              done_d = 1'b1;
            end else begin
              state_d = STEP;
              inc_d   = (dir_new == UP);
              dec_d   = (dir_new == DOWN);
            end
          end
        end
        STEP: begin
          if (dir_cur == NONE) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
`ifdef FFSR_PULSE_GAP_EN
            state_d = GAP;
`else
            inc_d = (dir_cur == UP);
            dec_d = (dir_cur == DOWN);
`endif
          end
        end
        GAP: begin
          state_d = STEP;
          inc_d   = (dir_cur == UP);
          dec_d   = (dir_cur == DOWN);
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tgt_q   <= '0;
      inc_q   <= 1'b0;
      dec_q   <= 1'b0;
      done_q  <= 1'b0;
      clr_o_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      inc_q   <= inc_d;
      dec_q   <= dec_d;
      done_q  <= done_d;
      clr_o_q <= clr_o_d;
    end
  end

  assign tgt_if.tgt_ready = (state_q == IDLE);
  assign busy             = (state_q != IDLE);
  assign inc              = inc_q;
  assign dec              = dec_q;
  assign done             = done_q;
  assign clr_o            = clr_o_q;

endmodule

// File: tb/tb_ffsr_pulse_binary_tx.sv
// Directed bench for ffsr_pulse_binary_tx with a downstream counter model.
// Expected pulse spacing follows FFSR_PULSE_GAP_EN when defined.
module tb_ffsr_pulse_binary_tx;

`ifdef FFSR_PULSE_GAP_EN
  localparam int S = 2;
`else
  localparam int S = 1;
`endif

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic       inc;
  logic       dec;
  logic       clr_o;
  logic [2:0] shadow;
  logic       busy;
  logic       done;
  logic [2:0] ds;
  int         n_chk;
  int         n_fail;
  logic [2:0] cur_sh;

  typedef struct {
    logic [2:0] tgt;
    int         n;
    bit         up;
  } vec_t;

  vec_t vt[10];

  ffsr_pulse_binary_tx_if #(.WIDTH(3)) tif ();

  ffsr_pulse_binary_tx #(.WIDTH(3)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (clr),
    .tgt_if (tif),
    .inc    (inc),
    .dec    (dec),
    .clr_o  (clr_o),
    .shadow (shadow),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream pulse-binary counter driven only by the DUT's pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ds <= '0;
    else if (clr_o)
      ds <= '0;
    else
      ds <= ds + 3'(inc) - 3'(dec);
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic run_xfer(input logic [2:0] t, input int n, input bit up);
    int         dn;
    bit         p;
    logic [2:0] esh;
    dn  = (n == 0) ? 1 : S * (n - 1) + 2;
    esh = cur_sh;
    @(negedge clk);
    chk("ready_pre", 32'(tif.tgt_ready), 1);
    tif.tgt_valid = 1'b1;
    tif.tgt       = t;
    @(posedge clk);
    #1 tif.tgt_valid = 1'b0;
    for (int c = 1; c <= dn; c++) begin
      @(negedge clk);
      p = (n > 0) && (c < dn) && (((c - 1) % S) == 0);
      chk("inc", 32'(inc), 32'(p && up));
      chk("dec", 32'(dec), 32'(p && !up));
      chk("done", 32'(done), 32'(c == dn));
      chk("busy", 32'(busy), 32'((n > 0) && (c < dn)));
      chk("ready", 32'(tif.tgt_ready), 32'(!((n > 0) && (c < dn))));
      chk("shadow", 32'(shadow), 32'(esh));
      chk("ds_match", 32'(ds), 32'(esh));
      if (p) esh = up ? esh + 3'd1 : esh - 3'd1;
    end
    chk("shadow_final", 32'(shadow), 32'(t));
    cur_sh = t;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    cur_sh = '0;
    rst_n  = 1'b0;
    clr    = 1'b0;
    tif.tgt_valid = 1'b0;
    tif.tgt       = '0;

    vt[0] = '{3'd5, 5, 1'b1};
    vt[1] = '{3'd2, 3, 1'b0};
    vt[2] = '{3'd2, 0, 1'b0};
    vt[3] = '{3'd7, 5, 1'b1};
    vt[4] = '{3'd0, 7, 1'b0};
    vt[5] = '{3'd0, 0, 1'b0};
    vt[6] = '{3'd1, 1, 1'b1};
    vt[7] = '{3'd6, 5, 1'b1};
    vt[8] = '{3'd6, 0, 1'b0};
    vt[9] = '{3'd3, 3, 1'b0};

    #3;
    chk("rst_inc", 32'(inc), 0);
    chk("rst_dec", 32'(dec), 0);
    chk("rst_clr_o", 32'(clr_o), 0);
    chk("rst_shadow", 32'(shadow), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_ready", 32'(tif.tgt_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++)
      run_xfer(vt[i].tgt, vt[i].n, vt[i].up);

    // Asynchronous reset in the middle of a 3 -> 7 transfer
    @(negedge clk);
    tif.tgt_valid = 1'b1;
    tif.tgt       = 3'd7;
    @(posedge clk);
    #1 tif.tgt_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_inc", 32'(inc), 0);
    chk("arst_dec", 32'(dec), 0);
    chk("arst_shadow", 32'(shadow), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_done", 32'(done), 0);
    chk("arst_clr_o", 32'(clr_o), 0);
    chk("arst_ready", 32'(tif.tgt_ready), 1);
    @(negedge clk);
    rst_n  = 1'b1;
    cur_sh = '0;
    run_xfer(3'd0, 0, 1'b0);

    // clr during the third pulse of a 0 -> 7 transfer
    @(negedge clk);
    tif.tgt_valid = 1'b1;
    tif.tgt       = 3'd7;
    @(posedge clk);
    #1 tif.tgt_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk("clr_pre_inc", 32'(inc), 32'(((c - 1) % S) == 0));
    end
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    @(negedge clk);
    chk("clr_inc", 32'(inc), 0);
    chk("clr_dec", 32'(dec), 0);
    chk("clr_shadow", 32'(shadow), 0);
    chk("clr_clr_o", 32'(clr_o), 1);
    chk("clr_done", 32'(done), 0);
    chk("clr_ready", 32'(tif.tgt_ready), 1);
    chk("clr_busy", 32'(busy), 0);
    @(negedge clk);
    chk("clr_o_once", 32'(clr_o), 0);
    chk("clr_no_done", 32'(done), 0);
    chk("clr_inc2", 32'(inc), 0);
    chk("clr_ds", 32'(ds), 0);
    cur_sh = '0;

    // clr coinciding with a handshake drops the target
    tif.tgt_valid = 1'b1;
    tif.tgt       = 3'd4;
    clr           = 1'b1;
    @(posedge clk);
    #1;
    tif.tgt_valid = 1'b0;
    clr           = 1'b0;
    @(negedge clk);
    chk("coll_clr_o", 32'(clr_o), 1);
    for (int c = 0; c < 3; c++) begin
      chk("coll_inc", 32'(inc), 0);
      chk("coll_done", 32'(done), 0);
      chk("coll_busy", 32'(busy), 0);
      chk("coll_shadow", 32'(shadow), 0);
      @(negedge clk);
    end

    run_xfer(3'd2, 2, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
